// File: rtl/bram_bus_pkg.sv
// Shared types and the address-window check for the s1/s2 BRAM bridges.
// Addresses are byte addresses; the BRAM is word-organised (32-bit words).
package bram_bus_pkg;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   error;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_IBUS, error: 1'b0};

    // Unsigned subtraction makes addresses below the base wrap to huge offsets,
    // so a single compare rejects both sides of the window.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned addr_w);
        return (addr - base) < (32'd4 << addr_w);
    endfunction

    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/bram_cpu_port_arbiter_if.sv
// Core ibus/dbus command-response buses plus the BRAM s1 port.
// master = core and BRAM side, slave = the arbiter.
interface bram_cpu_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              ibus_cmd_valid;
    logic              ibus_cmd_ready;
    logic [31:0]       ibus_cmd_pc;
    logic              ibus_rsp_valid;
    logic              ibus_rsp_error;
    logic [31:0]       ibus_rsp_inst;

    logic              dbus_cmd_valid;
    logic              dbus_cmd_ready;
    logic              dbus_cmd_wr;
    logic [31:0]       dbus_cmd_address;
    logic [31:0]       dbus_cmd_data;
    logic [3:0]        dbus_cmd_mask;
    logic              dbus_rsp_valid;
    logic              dbus_rsp_error;
    logic [31:0]       dbus_rsp_data;

    logic [ADDR_W-1:0] bram_address;
    logic              bram_chipselect;
    logic              bram_write;
    logic              bram_clken;
    logic [31:0]       bram_writedata;
    logic [3:0]        bram_byteenable;
    logic [31:0]       bram_readdata;

    logic              wr_error;

    modport master (
        output ibus_cmd_valid, ibus_cmd_pc,
        input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
        output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_mask,
        input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_error, dbus_rsp_data,
        input  bram_address, bram_chipselect, bram_write, bram_clken,
        input  bram_writedata, bram_byteenable,
        output bram_readdata,
        input  wr_error
    );

    modport slave (
        input  ibus_cmd_valid, ibus_cmd_pc,
        output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
        input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_mask,
        output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_error, dbus_rsp_data,
        output bram_address, bram_chipselect, bram_write, bram_clken,
        output bram_writedata, bram_byteenable,
        input  bram_readdata,
        output wr_error
    );

endinterface

// File: rtl/bram_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer only moves on contended cycles,
// so an uncontested requester never costs the other its next turn.
module bram_rr_arbiter2
    import bram_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ibus_req,
    input  logic dbus_req,
    output logic ibus_ready,
    output logic dbus_ready
);

    owner_t next_owner_reg;
    owner_t next_owner_next;
    logic   contended;

    always_comb begin
        contended       = ibus_req && dbus_req;
        ibus_ready      = !dbus_req || (next_owner_reg == OWN_IBUS);
        dbus_ready      = !ibus_req || (next_owner_reg == OWN_DBUS);
        next_owner_next = next_owner_reg;
        if (contended) begin
            next_owner_next = (next_owner_reg == OWN_DBUS) ? OWN_IBUS : OWN_DBUS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_owner_reg <= OWN_DBUS;
        end else begin
            next_owner_reg <= next_owner_next;
        end
    end

endmodule

// File: rtl/bram_cpu_port_arbiter.sv
// Merges core ibus/dbus onto BRAM port s1; read responses return in order via
// a tag pipe matched to the BRAM read latency.
module bram_cpu_port_arbiter
    import bram_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 1
) (
    input logic                     clk,
    input logic                     reset,
    bram_cpu_port_arbiter_if.slave  bus
);

    logic                          ibus_ready;
    logic                          dbus_ready;
    logic                          ibus_accept;
    logic                          dbus_accept;
    logic                          dbus_is_write;
    logic                          hit;
    logic [31:0]                   cmd_address;
    logic [31:0]                   word_off;
    logic                          unused_word_bits;
    tag_t                          push_tag;
    tag_t                          out_tag;
    tag_t [READ_LATENCY-1:0]       pipe_reg;
    tag_t [READ_LATENCY-1:0]       pipe_next;
    logic                          wr_error_reg;
    logic                          wr_error_next;

    bram_rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .ibus_req   (bus.ibus_cmd_valid),
        .dbus_req   (bus.dbus_cmd_valid),
        .ibus_ready (ibus_ready),
        .dbus_ready (dbus_ready)
    );

    // Only one requester can be accepted per cycle, so one address decode serves both.
    always_comb begin
        ibus_accept   = bus.ibus_cmd_valid && ibus_ready;
        dbus_accept   = bus.dbus_cmd_valid && dbus_ready;
        dbus_is_write = dbus_accept && bus.dbus_cmd_wr;
        cmd_address   = dbus_accept ? bus.dbus_cmd_address : bus.ibus_cmd_pc;
        hit           = in_window(cmd_address, BASE_ADDR, ADDR_W);
        word_off      = word_offset(cmd_address, BASE_ADDR);

        bus.ibus_cmd_ready  = ibus_ready;
        bus.dbus_cmd_ready  = dbus_ready;
        bus.bram_clken      = 1'b1;
        bus.bram_address    = word_off[ADDR_W-1:0];
        bus.bram_writedata  = bus.dbus_cmd_data;
        bus.bram_chipselect = (ibus_accept || dbus_accept) && hit;
        bus.bram_write      = dbus_is_write && hit;
        bus.bram_byteenable = dbus_is_write ? bus.dbus_cmd_mask : 4'hF;

        push_tag = TAG_IDLE;
        if (ibus_accept || (dbus_accept && !bus.dbus_cmd_wr)) begin
            push_tag = '{valid: 1'b1,
                         owner: dbus_accept ? OWN_DBUS : OWN_IBUS,
                         error: !hit};
        end

        wr_error_next = wr_error_reg || (dbus_is_write && !hit);
    end

    assign unused_word_bits = &{1'b0, word_off[31:ADDR_W]};

    // Tag pipe: stage gi holds the tag of the read accepted gi+1 cycles ago.
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag_pipe
            if (gi == 0) begin : g_head
                assign pipe_next[gi] = push_tag;
            end else begin : g_shift
                assign pipe_next[gi] = pipe_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_reg     <= '0;
            wr_error_reg <= 1'b0;
        end else begin
            pipe_reg     <= pipe_next;
            wr_error_reg <= wr_error_next;
        end
    end

    assign out_tag = pipe_reg[READ_LATENCY-1];

    // Error responses carry zero data since the BRAM was never read for them.
    always_comb begin
        bus.ibus_rsp_valid = out_tag.valid && (out_tag.owner == OWN_IBUS);
        bus.dbus_rsp_valid = out_tag.valid && (out_tag.owner == OWN_DBUS);
        bus.ibus_rsp_error = bus.ibus_rsp_valid && out_tag.error;
        bus.dbus_rsp_error = bus.dbus_rsp_valid && out_tag.error;
        bus.ibus_rsp_inst  = (bus.ibus_rsp_valid && !out_tag.error) ? bus.bram_readdata : 32'h0;
        bus.dbus_rsp_data  = (bus.dbus_rsp_valid && !out_tag.error) ? bus.bram_readdata : 32'h0;
        bus.wr_error       = wr_error_reg;
    end

endmodule

// File: tb/tb_bram_cpu_port_arbiter.sv
// Drives two arbiter instances (latency 1 / base 0, latency 2 / base 0x8000_0000)
// with identical offset-relative traffic and scoreboards their responses.
module tb_bram_cpu_port_arbiter;

    localparam logic [31:0] WINDOW = 32'h0000_1000;

    typedef struct {
        bit          owner_d;
        bit          err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ibus_valid;
    logic [31:0] ibus_off;
    logic        dbus_valid;
    logic        dbus_wr;
    logic [31:0] dbus_off;
    logic [31:0] dbus_data;
    logic [3:0]  dbus_mask;

    logic [1:0]  rdy_i, rdy_d, cs, wr_err, i_v, d_v, i_err, d_err;
    logic [31:0] i_data [2];
    logic [31:0] d_data [2];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          ptr_d;
    bit          exp_wr_err;
    logic [31:0] ref_mem [1024];
    exp_t        q0 [$];
    exp_t        q1 [$];

    function automatic logic [31:0] init_word(input int j);
        if (j == 4) return 32'hDEADBEEF;
        if (j == 7) return 32'h0;
        return (32'(j) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inst
            localparam int          RL   = (gi == 0) ? 1 : 2;
            localparam logic [31:0] BASE = (gi == 0) ? 32'h0000_0000 : 32'h8000_0000;

            bram_cpu_port_arbiter_if #(.ADDR_W(10)) bus ();
            logic [31:0] mem [1024];
            logic [31:0] rd1, rd2;

            assign bus.ibus_cmd_valid   = ibus_valid;
            assign bus.ibus_cmd_pc      = BASE + ibus_off;
            assign bus.dbus_cmd_valid   = dbus_valid;
            assign bus.dbus_cmd_wr      = dbus_wr;
            assign bus.dbus_cmd_address = BASE + dbus_off;
            assign bus.dbus_cmd_data    = dbus_data;
            assign bus.dbus_cmd_mask    = dbus_mask;

            bram_cpu_port_arbiter #(
                .BASE_ADDR    (BASE),
                .ADDR_W       (10),
                .READ_LATENCY (RL)
            ) dut (
                .clk   (clk),
                .reset (rst),
                .bus   (bus)
            );

            initial for (int j = 0; j < 1024; j++) mem[j] <= init_word(j);

            always @(posedge clk) begin
                if (bus.bram_chipselect) begin
                    if (bus.bram_write) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.bram_byteenable[b])
                                mem[bus.bram_address][8*b +: 8] <= bus.bram_writedata[8*b +: 8];
                    end else begin
                        rd1 <= mem[bus.bram_address];
                    end
                end
                rd2 <= rd1;
            end
            assign bus.bram_readdata = (RL == 1) ? rd1 : rd2;

            assign rdy_i[gi]  = bus.ibus_cmd_ready;
            assign rdy_d[gi]  = bus.dbus_cmd_ready;
            assign cs[gi]     = bus.bram_chipselect;
            assign wr_err[gi] = bus.wr_error;
            assign i_v[gi]    = bus.ibus_rsp_valid;
            assign d_v[gi]    = bus.dbus_rsp_valid;
            assign i_err[gi]  = bus.ibus_rsp_error;
            assign d_err[gi]  = bus.dbus_rsp_error;
            assign i_data[gi] = bus.ibus_rsp_inst;
            assign d_data[gi] = bus.dbus_rsp_data;
        end
    endgenerate

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    task automatic push_exp(input bit owner_d, input logic [31:0] off);
        exp_t e;
        e.owner_d = owner_d;
        e.err     = !(off < WINDOW);
        e.data    = e.err ? 32'h0 : ref_mem[off[11:2]];
        e.due     = cyc + 1;
        q0.push_back(e);
        e.due     = cyc + 2;
        q1.push_back(e);
    endtask

    // Response scoreboard: every strobe must match the oldest outstanding read.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (i_v[k] || d_v[k]) begin
                exp_t e;
                int   qsize;
                qsize = (k == 0) ? q0.size() : q1.size();
                check("rsp_pending", k, 32'(qsize != 0), 32'd1);
                if (qsize != 0) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    $display("rsp inst%0d cyc=%0d owner=%s err=%0d data=%h", k, cyc,
                             d_v[k] ? "D" : "I", d_v[k] ? d_err[k] : i_err[k],
                             d_v[k] ? d_data[k] : i_data[k]);
                    check("rsp_both", k, 32'(i_v[k] & d_v[k]), 32'd0);
                    check("rsp_owner", k, 32'(d_v[k]), 32'(e.owner_d));
                    check("rsp_error", k, 32'(d_v[k] ? d_err[k] : i_err[k]), 32'(e.err));
                    check("rsp_data", k, d_v[k] ? d_data[k] : i_data[k], e.data);
                    check("rsp_cycle", k, 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic step(input bit iv, input logic [31:0] ioff, input bit dv, input bit dwr,
                        input logic [31:0] doff, input logic [31:0] dd, input logic [3:0] dm,
                        output bit i_won, output bit d_won);
        bit          exp_ri, exp_rd, exp_cs, new_wr_err;
        logic [31:0] woff;
        ibus_valid = iv;  ibus_off = ioff;
        dbus_valid = dv;  dbus_wr = dwr; dbus_off = doff; dbus_data = dd; dbus_mask = dm;
        exp_ri = !dv || !ptr_d;
        exp_rd = !iv || ptr_d;
        i_won  = iv && exp_ri;
        d_won  = dv && exp_rd;
        if (iv && dv) ptr_d = !ptr_d;
        woff   = d_won ? doff : ioff;
        exp_cs = (i_won || d_won) && (woff < WINDOW);
        new_wr_err = exp_wr_err;
        if (i_won) push_exp(1'b0, ioff);
        if (d_won && !dwr) push_exp(1'b1, doff);
        if (d_won && dwr) begin
            if (doff < WINDOW) begin
                for (int b = 0; b < 4; b++)
                    if (dm[b]) ref_mem[doff[11:2]][8*b +: 8] = dd[8*b +: 8];
            end else begin
                new_wr_err = 1'b1;
            end
        end
        $display("cmd cyc=%0d iv=%0d ioff=%h dv=%0d wr=%0d doff=%h data=%h mask=%h grant=%s",
                 cyc, iv, ioff, dv, dwr, doff, dd, dm, d_won ? "D" : (i_won ? "I" : "-"));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("ibus_ready", k, 32'(rdy_i[k]), 32'(exp_ri));
            check("dbus_ready", k, 32'(rdy_d[k]), 32'(exp_rd));
            check("chipselect", k, 32'(cs[k]), 32'(exp_cs));
            check("wr_error", k, 32'(wr_err[k]), 32'(exp_wr_err));
        end
        exp_wr_err = new_wr_err;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle();
        for (int k = 0; k < 2; k++) begin
            check("idle_ibus_ready", k, 32'(rdy_i[k]), 32'd1);
            check("idle_dbus_ready", k, 32'(rdy_d[k]), 32'd1);
            check("idle_rsp_valid", k, 32'({i_v[k], d_v[k]}), 32'd0);
            check("idle_rsp_error", k, 32'({i_err[k], d_err[k]}), 32'd0);
            check("idle_ibus_inst", k, i_data[k], 32'h0);
            check("idle_dbus_data", k, d_data[k], 32'h0);
            check("idle_wr_error", k, 32'(wr_err[k]), 32'd0);
            check("idle_chipselect", k, 32'(cs[k]), 32'd0);
        end
    endtask

    initial begin
        bit          iw, dw;
        logic [31:0] ia, da;
        rst = 1'b1;
        ibus_valid = 1'b0; ibus_off = '0;
        dbus_valid = 1'b0; dbus_wr = 1'b0; dbus_off = '0; dbus_data = '0; dbus_mask = '0;
        ptr_d = 1'b1;
        exp_wr_err = 1'b0;
        for (int j = 0; j < 1024; j++) ref_mem[j] = init_word(j);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle();
        @(posedge clk);
        #1;

        // fetches, including ignored low address bits
        step(1, 32'h10, 0, 0, 0, 0, 0, iw, dw);
        step(1, 32'h13, 0, 0, 0, 0, 0, iw, dw);
        step(0, 0, 0, 0, 0, 0, 0, iw, dw);
        // partial write then immediate readback, mask-0 write, last word
        step(0, 0, 1, 1, 32'h1C, 32'h11223344, 4'b0101, iw, dw);
        step(0, 0, 1, 0, 32'h1C, 0, 0, iw, dw);
        step(0, 0, 1, 1, 32'h1C, 32'hFFFFFFFF, 4'b0000, iw, dw);
        step(0, 0, 1, 0, 32'h1C, 0, 0, iw, dw);
        step(0, 0, 1, 1, 32'hFFC, 32'hCAFEF00D, 4'hF, iw, dw);
        step(1, 32'hFFC, 0, 0, 0, 0, 0, iw, dw);

        // both buses busy for 8 cycles; each holds its command until accepted
        ia = 32'h20;
        da = 32'h40;
        for (int c = 0; c < 8; c++) begin
            step(1, ia, 1, 0, da, 0, 0, iw, dw);
            if (iw) ia += 4;
            if (dw) da += 4;
        end

        // window boundaries
        step(0, 0, 1, 0, 32'h1000, 0, 0, iw, dw);
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, iw, dw);
        step(0, 0, 1, 1, 32'h1000, 32'h55AA55AA, 4'hF, iw, dw);
        step(0, 0, 1, 0, 32'h1000, 0, 0, iw, dw);
        step(0, 0, 0, 0, 0, 0, 0, iw, dw);
        step(0, 0, 0, 0, 0, 0, 0, iw, dw);

        // reset right after a read is accepted: no response may follow
        step(0, 0, 1, 0, 32'h10, 0, 0, iw, dw);
        rst = 1'b1;
        ibus_valid = 1'b0;
        dbus_valid = 1'b0;
        q0.delete();
        q1.delete();
        ptr_d = 1'b1;
        exp_wr_err = 1'b0;
        $display("reset asserted cyc=%0d", cyc);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle();
        @(posedge clk);
        #1;

        // dbus wins the first contention after reset
        step(1, 32'h10, 1, 0, 32'h1C, 0, 0, iw, dw);
        step(1, 32'h10, 0, 0, 0, 0, 0, iw, dw);
        step(0, 0, 0, 0, 0, 0, 0, iw, dw);
        step(0, 0, 0, 0, 0, 0, 0, iw, dw);

        check("q_empty", 0, 32'(q0.size()), 32'd0);
        check("q_empty", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
